data_ram: RTL and testbench

Dual-port, word-organized data memory for the pipelined RISC-V core, sitting in the MEM/WB stage. Port A serves the CPU datapath: load/store with per-byte write enables, data already lane-aligned by the caller. Port B is an independent debug port with the same capabilities. Both ports read synchronously, so the memory maps onto FPGA block RAM.

---
 rtl/data_ram.sv | 52 +++++
 tb/tb_data_ram.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// rtl/data_ram.sv - dual-port byte-writable data memory, synchronous read-first on both ports
module data_ram #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  wea,
  input  logic [29:0] addra,
  input  logic [31:0] dina,
  output logic [31:0] douta,
  input  logic [3:0]  web,
  input  logic [29:0] addrb,
  input  logic [31:0] dinb,
  output logic [31:0] doutb
);

  localparam int DEPTH = 1 << ADDR_W;

  // Configuration-time zero fill; reset never touches the array.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic [ADDR_W-1:0] idx_a;
  logic [ADDR_W-1:0] idx_b;

  assign idx_a = addra[ADDR_W-1:0];
  assign idx_b = addrb[ADDR_W-1:0];

  // Upper word-address bits are intentionally ignored (addresses wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addra[29:ADDR_W], addrb[29:ADDR_W]};

  // Port B lanes are scheduled first so a same-lane port A write overrides it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (web[i]) mem[idx_b][8*i +: 8] <= dinb[8*i +: 8];
        if (wea[i]) mem[idx_a][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta <= '0;
      doutb <= '0;
    end else begin
      douta <= mem[idx_a];
      doutb <= mem[idx_b];
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - randomized self-checking bench for data_ram against a word-array model
module tb_data_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wea, web;
  logic [29:0] addra, addrb;
  logic [31:0] dina, dinb, douta, doutb;

  logic [31:0] model [4096];
  logic [31:0] exp_a, exp_b;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_ram #(.ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
  );

  // Advance one clock: predict reads from the old contents, then apply writes (A wins per lane).
  task automatic step();
    int ia, ib;
    ia = int'(addra % 30'd4096);
    ib = int'(addrb % 30'd4096);
    if (rst_n) begin
      exp_a = model[ia];
      exp_b = model[ib];
      for (int l = 0; l < 4; l++) begin
        if (web[l]) model[ib][8*l +: 8] = dinb[8*l +: 8];
        if (wea[l]) model[ia][8*l +: 8] = dina[8*l +: 8];
      end
    end else begin
      exp_a = 32'h0;
      exp_b = 32'h0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wea = 4'h0; web = 4'h0; dina = 32'h0; dinb = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); addra = 30'h0; addrb = 30'h0;
    #2;
    n_cmp++; if (douta !== 32'h0) begin n_fail++; $display("FAIL reset_douta got %h want %h", douta, 32'h0); end
    n_cmp++; if (doutb !== 32'h0) begin n_fail++; $display("FAIL reset_doutb got %h want %h", doutb, 32'h0); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (douta !== 32'h0) begin n_fail++; $display("FAIL release_hold_douta got %h want %h", douta, 32'h0); end
    @(negedge clk);
  endtask

  task automatic test_powerup();
    idle(); addra = 30'h0FF; addrb = 30'h0FF;
    step();
    n_cmp++; if (douta !== 32'h0) begin n_fail++; $display("FAIL powerup_douta got %h want %h", douta, 32'h0); end
    n_cmp++; if (doutb !== 32'h0) begin n_fail++; $display("FAIL powerup_doutb got %h want %h", doutb, 32'h0); end
  endtask

  task automatic test_full_word();
    idle(); wea = 4'hF; addra = 30'd5; dina = 32'hDEADBEEF; addrb = 30'd0;
    step();
    n_cmp++; if (douta !== 32'h0) begin n_fail++; $display("FAIL full_word_readfirst got %h want %h", douta, 32'h0); end
    idle(); addra = 30'd5; addrb = 30'd5;
    step();
    n_cmp++; if (douta !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_word_douta got %h want %h", douta, 32'hDEADBEEF); end
    n_cmp++; if (doutb !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_word_doutb got %h want %h", doutb, 32'hDEADBEEF); end
  endtask

  task automatic test_byte_lanes();
    idle(); wea = 4'b0100; addra = 30'd5; dina = 32'h00AA0000;
    step();
    idle(); wea = 4'b0001; addra = 30'd5; dina = 32'h00000011;
    step();
    idle(); addra = 30'd5; addrb = 30'd5;
    step();
    n_cmp++; if (douta !== 32'hDEAABE11) begin n_fail++; $display("FAIL byte_lanes_douta got %h want %h", douta, 32'hDEAABE11); end
    n_cmp++; if (doutb !== 32'hDEAABE11) begin n_fail++; $display("FAIL byte_lanes_doutb got %h want %h", doutb, 32'hDEAABE11); end
  endtask

  task automatic test_collision();
    idle(); wea = 4'hF; addra = 30'd7; dina = 32'h11111111;
    step();
    idle(); wea = 4'hF; addra = 30'd7; dina = 32'h22222222; addrb = 30'd7;
    step();
    n_cmp++; if (douta !== 32'h11111111) begin n_fail++; $display("FAIL rdw_douta got %h want %h", douta, 32'h11111111); end
    n_cmp++; if (doutb !== 32'h11111111) begin n_fail++; $display("FAIL rdw_doutb got %h want %h", doutb, 32'h11111111); end
    idle(); addra = 30'd7; addrb = 30'd7;
    step();
    n_cmp++; if (douta !== 32'h22222222) begin n_fail++; $display("FAIL rdw_after_douta got %h want %h", douta, 32'h22222222); end
    n_cmp++; if (doutb !== 32'h22222222) begin n_fail++; $display("FAIL rdw_after_doutb got %h want %h", doutb, 32'h22222222); end
    idle(); wea = 4'hF; web = 4'hF; addra = 30'd9; addrb = 30'd9; dina = 32'hAAAAAAAA; dinb = 32'h55555555;
    step();
    idle(); addra = 30'd9; addrb = 30'd9;
    step();
    n_cmp++; if (douta !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL dual_write_douta got %h want %h", douta, 32'hAAAAAAAA); end
    n_cmp++; if (doutb !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL dual_write_doutb got %h want %h", doutb, 32'hAAAAAAAA); end
  endtask

  task automatic test_reset_midop();
    idle(); addra = 30'd5; addrb = 30'd5;
    step();
    n_cmp++; if (douta !== 32'hDEAABE11) begin n_fail++; $display("FAIL pre_reset_douta got %h want %h", douta, 32'hDEAABE11); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (douta !== 32'h0) begin n_fail++; $display("FAIL async_reset_douta got %h want %h", douta, 32'h0); end
    n_cmp++; if (doutb !== 32'h0) begin n_fail++; $display("FAIL async_reset_doutb got %h want %h", doutb, 32'h0); end
    idle(); wea = 4'hF; addra = 30'd3; dina = 32'hFFFFFFFF; web = 4'hF; addrb = 30'd4; dinb = 32'hEEEEEEEE;
    step();
    n_cmp++; if (douta !== 32'h0) begin n_fail++; $display("FAIL in_reset_douta got %h want %h", douta, 32'h0); end
    rst_n = 1'b1;
    idle(); addra = 30'd3; addrb = 30'd5;
    step();
    n_cmp++; if (douta !== 32'h0) begin n_fail++; $display("FAIL suppressed_write_a got %h want %h", douta, 32'h0); end
    n_cmp++; if (doutb !== 32'hDEAABE11) begin n_fail++; $display("FAIL retained_word got %h want %h", doutb, 32'hDEAABE11); end
    idle(); addra = 30'd4; addrb = 30'd4;
    step();
    n_cmp++; if (doutb !== 32'h0) begin n_fail++; $display("FAIL suppressed_write_b got %h want %h", doutb, 32'h0); end
  endtask

  task automatic test_wrap();
    idle(); wea = 4'hF; addra = 30'h1003; dina = 32'h12345678;
    step();
    idle(); addrb = 30'h003; addra = 30'h2003;
    step();
    n_cmp++; if (doutb !== 32'h12345678) begin n_fail++; $display("FAIL wrap_doutb got %h want %h", doutb, 32'h12345678); end
    n_cmp++; if (douta !== 32'h12345678) begin n_fail++; $display("FAIL wrap_douta got %h want %h", douta, 32'h12345678); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      wea   = 4'($urandom_range(0, 15));
      web   = 4'($urandom_range(0, 15));
      addra = 30'($urandom_range(0, 7)) | (30'($urandom_range(0, 3)) << 12);
      addrb = 30'($urandom_range(0, 7)) | (30'($urandom_range(0, 3)) << 12);
      dina  = $urandom;
      dinb  = $urandom;
      step();
      n_cmp++; if (douta !== exp_a) begin n_fail++; $display("FAIL random_douta[%0d] got %h want %h", k, douta, exp_a); end
      n_cmp++; if (doutb !== exp_b) begin n_fail++; $display("FAIL random_doutb[%0d] got %h want %h", k, doutb, exp_b); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) model[i] = 32'h0;
    test_reset();
    test_powerup();
    test_full_word();
    test_byte_lanes();
    test_collision();
    test_reset_midop();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
